maze_game_ctrl: RTL and testbench
=================================

Name: maze_game_ctrl

Overview:
- Parametrised successor to the top-level maze game logic. Runs the game flow: menu, timed map reveal, playing, won and lost.
- Owns the player position, validated movement, wall collision and goal detection against an external synchronous map ROM with one row per word.
- Generalised in map size, start and goal tiles, and reveal time per difficulty. Adds difficulty-dependent collision policy, bounds checking, a move counter and a win condition.
- Sits between the debounced button pulses and the VGA renderer.

Parameters:
MAP_W, 30, tiles per row; map ROM word width
MAP_H, 21, rows in the map ROM
POS_W, 8, width of the player_x and player_y coordinates
START_X, 0, player spawn column
START_Y, 20, player spawn row
GOAL_X, 29, goal column
GOAL_Y, 0, goal row
SHOW_EASY, 1000000, map reveal time in cycles, easy
SHOW_MED, 500000, map reveal time in cycles, medium
SHOW_HARD, 250000, map reveal time in cycles, hard
TMR_W, 24, width of the reveal timer
CNT_W, 10, width of the move counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; begins a game from MENU, returns to MENU from WON or LOST
diff_sel  in  2  difficulty: 0 easy, 1 medium, 2 or 3 hard; sampled on start
move_up  in  1  one-cycle move pulse, y-1
move_down  in  1  one-cycle move pulse, y+1
move_left  in  1  one-cycle move pulse, x-1
move_right  in  1  one-cycle move pulse, x+1
map_addr  out  clog2(MAP_H)  registered ROM row address
map_data  in  MAP_W  ROM row; valid 2 cycles after map_addr changes (ROM registers the address); bit i = tile x=i; 1 = wall
state  out  3  MENU=0, SHOW=1, PLAY=2, REQ=3, CHECK=4, WON=5, LOST=6
show_map  out  1  high while in SHOW; renderer draws walls only when high
player_x  out  POS_W  current column
player_y  out  POS_W  current row
difficulty  out  2  latched difficulty: 0, 1 or 2
move_count  out  CNT_W  committed moves; saturates at all-ones
won  out  1  high in WON
lost  out  1  high in LOST

Behaviour:
- Reset (reset==0 at a clk edge) has priority over everything, including mid-move. It sets:
  - state=MENU, show_map=0, won=0, lost=0
  - player_x=START_X, player_y=START_Y, map_addr=START_Y
  - move_count=0, difficulty=0, timer=0
- All outputs are registered.
- MENU:
  - Waits for start.
  - On start: latch difficulty (diff_sel 3 maps to 2), load timer with SHOW_x-1, reset player to START, clear move_count, go to SHOW.
- SHOW:
  - show_map=1; timer decrements every cycle.
  - Exits to PLAY on the cycle timer==0, so show_map is high for exactly SHOW_x cycles.
  - Move pulses are ignored.
- PLAY:
  - Accepts at most one move per cycle, priority up > down > left > right; lower-priority simultaneous pulses are dropped.
  - Out of bounds: a target with x<0, x>=MAP_W, y<0 or y>=MAP_H (check by compare before wrap) is rejected silently. State stays PLAY, nothing changes.
  - Otherwise: latch target, set map_addr=target_y, go to REQ.
- REQ: one wait cycle for the ROM address register; go to CHECK.
- CHECK: evaluate map_data[target_x].
  - Wall, easy or medium: move blocked, position unchanged, return to PLAY.
  - Wall, hard: go to LOST; position unchanged.
  - Free: commit player_x/player_y=target, move_count+1 (saturating).
    - If target==(GOAL_X,GOAL_Y): go to WON.
    - Otherwise: return to PLAY.
  - After CHECK, map_addr=player_y (the new row).
- Latency: a move pulse in cycle N updates the position at the end of cycle N+2. Pulses arriving in REQ or CHECK are dropped, not queued.
- WON / LOST:
  - won or lost held high; position and move_count frozen.
  - start returns to MENU (position reset to START, won and lost cleared). A new start from MENU is required to replay.
- start in SHOW, PLAY, REQ or CHECK is ignored. diff_sel is only sampled on the MENU start.
- The spawn tile is never checked. The spawn sitting on the goal is not a win until a move is committed.

Test Plan:
- Reset low mid-CHECK, then high -> state=0, player=(0,20), move_count=0, won=0, lost=0, map_addr=20.
- MENU, diff_sel=1, start at cycle 0 -> show_map high for exactly 500000 cycles, state=PLAY on the next cycle, difficulty=1.
- PLAY at (0,20), move_left, then move_down -> both rejected with no REQ entry; move_up and move_right in the same cycle with row 19 bit0=0 -> player=(0,19) 3 cycles later, move_count=1.
- Row 19 bit1=1, player at (1,20), move_up: easy -> player stays (1,20), state=PLAY, move_count unchanged; hard -> state=LOST, lost=1.
- Player at (28,0), row 0 bit29=0, move_right -> player=(29,0), state=WON, won=1; then start -> MENU, player=(0,20), won=0.
- Move pulses issued during REQ and during SHOW -> ignored; move_count increments exactly once per committed move and saturates at 1023.

Source files
------------

// File: rtl/maze_game_ctrl.sv
// Maze game flow controller: menu, timed map reveal, play, won, lost.
// Owns the player position. Each move is checked against an external
// synchronous map ROM that holds one row per word (bit i = column i, 1 = wall).
//
// state | meaning
// ------+-------------------------------------------------------------
// MENU  | idle; start latches difficulty and begins the reveal
// SHOW  | map visible; reveal timer counts down to zero
// PLAY  | accepting one move pulse; bounds checked before the ROM lookup
// REQ   | wait cycle while the ROM registers the target row address
// CHECK | target tile read; commit, block, lose or win
// WON   | goal reached; position frozen until start
// LOST  | hit a wall on hard; position frozen until start
module maze_game_ctrl #(
   parameter int MAP_W     = 30,
   parameter int MAP_H     = 21,
   parameter int POS_W     = 8,
   parameter int START_X   = 0,
   parameter int START_Y   = 20,
   parameter int GOAL_X    = 29,
   parameter int GOAL_Y    = 0,
   parameter int SHOW_EASY = 1000000,
   parameter int SHOW_MED  = 500000,
   parameter int SHOW_HARD = 250000,
   parameter int TMR_W     = 24,
   parameter int CNT_W     = 10,
   parameter int AW        = $clog2(MAP_H)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       diff_sel,
   input  logic             move_up,
   input  logic             move_down,
   input  logic             move_left,
   input  logic             move_right,
   output logic [AW-1:0]    map_addr,
   input  logic [MAP_W-1:0] map_data,
   output logic [2:0]       state,
   output logic             show_map,
   output logic [POS_W-1:0] player_x,
   output logic [POS_W-1:0] player_y,
   output logic [1:0]       difficulty,
   output logic [CNT_W-1:0] move_count,
   output logic             won,
   output logic             lost
);

   localparam logic [2:0] MENU  = 3'd0;
   localparam logic [2:0] SHOW  = 3'd1;
   localparam logic [2:0] PLAY  = 3'd2;
   localparam logic [2:0] REQ   = 3'd3;
   localparam logic [2:0] CHECK = 3'd4;
   localparam logic [2:0] WON   = 3'd5;
   localparam logic [2:0] LOST  = 3'd6;

   localparam logic [MAP_W-1:0] ONE_BIT = {{(MAP_W-1){1'b0}}, 1'b1};

   logic [TMR_W-1:0] timer;
   logic [POS_W-1:0] tgt_x;
   logic [POS_W-1:0] tgt_y;

   logic             mv_ok;
   logic [POS_W-1:0] tgt_x_nx;
   logic [POS_W-1:0] tgt_y_nx;
   logic [1:0]       diff_lat;
   logic [TMR_W-1:0] show_load;
   logic             tgt_wall;
   logic             tgt_goal;

   // Pick the single highest-priority move and reject it if it leaves the map.
   // A rejected higher-priority pulse still suppresses the lower ones.
   always_comb begin
      mv_ok    = 1'b0;
      tgt_x_nx = player_x;
      tgt_y_nx = player_y;
      if (move_up) begin
         if (player_y != '0) begin
            mv_ok    = 1'b1;
            tgt_y_nx = player_y - 1'b1;
         end
      end else if (move_down) begin
         if (int'(player_y) < MAP_H - 1) begin
            mv_ok    = 1'b1;
            tgt_y_nx = player_y + 1'b1;
         end
      end else if (move_left) begin
         if (player_x != '0) begin
            mv_ok    = 1'b1;
            tgt_x_nx = player_x - 1'b1;
         end
      end else if (move_right) begin
         if (int'(player_x) < MAP_W - 1) begin
            mv_ok    = 1'b1;
            tgt_x_nx = player_x + 1'b1;
         end
      end
   end

   // Difficulty code 3 is folded onto hard; reveal length follows difficulty.
   always_comb begin
      diff_lat = (diff_sel == 2'd3) ? 2'd2 : diff_sel;
      case (diff_lat)
         2'd0:    show_load = TMR_W'(SHOW_EASY - 1);
         2'd1:    show_load = TMR_W'(SHOW_MED - 1);
         default: show_load = TMR_W'(SHOW_HARD - 1);
      endcase
      tgt_wall = |(map_data & (ONE_BIT << tgt_x));
      tgt_goal = (tgt_x == POS_W'(GOAL_X)) && (tgt_y == POS_W'(GOAL_Y));
   end

   // Game flow sequencer; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= MENU;
         show_map   <= 1'b0;
         won        <= 1'b0;
         lost       <= 1'b0;
         player_x   <= POS_W'(START_X);
         player_y   <= POS_W'(START_Y);
         map_addr   <= AW'(START_Y);
         move_count <= '0;
         difficulty <= 2'd0;
         timer      <= '0;
         tgt_x      <= '0;
         tgt_y      <= '0;
      end else begin
         case (state)
            MENU: begin
               if (start) begin
                  difficulty <= diff_lat;
                  timer      <= show_load;
                  player_x   <= POS_W'(START_X);
                  player_y   <= POS_W'(START_Y);
                  map_addr   <= AW'(START_Y);
                  move_count <= '0;
                  show_map   <= 1'b1;
                  state      <= SHOW;
               end
            end
            SHOW: begin
               if (timer == '0) begin
                  show_map <= 1'b0;
                  state    <= PLAY;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            PLAY: begin
               if (mv_ok) begin
                  tgt_x    <= tgt_x_nx;
                  tgt_y    <= tgt_y_nx;
                  map_addr <= AW'(tgt_y_nx);
                  state    <= REQ;
               end
            end
            REQ: begin
               state <= CHECK;
            end
            CHECK: begin
               if (tgt_wall) begin
                  map_addr <= AW'(player_y);
                  if (difficulty == 2'd2) begin
                     lost  <= 1'b1;
                     state <= LOST;
                  end else begin
                     state <= PLAY;
                  end
               end else begin
                  player_x <= tgt_x;
                  player_y <= tgt_y;
                  map_addr <= AW'(tgt_y);
                  if (move_count != '1) begin
                     move_count <= move_count + 1'b1;
                  end
                  if (tgt_goal) begin
                     won   <= 1'b1;
                     state <= WON;
                  end else begin
                     state <= PLAY;
                  end
               end
            end
            WON, LOST: begin
               if (start) begin
                  won      <= 1'b0;
                  lost     <= 1'b0;
                  player_x <= POS_W'(START_X);
                  player_y <= POS_W'(START_Y);
                  map_addr <= AW'(START_Y);
                  state    <= MENU;
               end
            end
            default: begin
               state <= MENU;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl with short reveal times and a 3-bit
// move counter so saturation is reachable. The map ROM model registers
// the address, giving the two-cycle read latency the controller expects.
module tb_maze_game_ctrl;

   localparam int MAP_W = 30;
   localparam int MAP_H = 21;
   localparam int AW    = 5;
   localparam int S_E   = 12;
   localparam int S_M   = 8;
   localparam int S_H   = 5;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       diff_sel = 2'd0;
   logic             move_up = 1'b0;
   logic             move_down = 1'b0;
   logic             move_left = 1'b0;
   logic             move_right = 1'b0;
   logic [AW-1:0]    map_addr;
   logic [MAP_W-1:0] map_data;
   logic [2:0]       state;
   logic             show_map;
   logic [7:0]       player_x;
   logic [7:0]       player_y;
   logic [1:0]       difficulty;
   logic [CNT_W-1:0] move_count;
   logic             won;
   logic             lost;

   logic [MAP_W-1:0] rom [MAP_H];

   int checks = 0;
   int errors = 0;

   maze_game_ctrl #(
      .MAP_W(MAP_W), .MAP_H(MAP_H), .POS_W(8),
      .START_X(0), .START_Y(20), .GOAL_X(29), .GOAL_Y(0),
      .SHOW_EASY(S_E), .SHOW_MED(S_M), .SHOW_HARD(S_H),
      .TMR_W(24), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .diff_sel(diff_sel),
      .move_up(move_up), .move_down(move_down),
      .move_left(move_left), .move_right(move_right),
      .map_addr(map_addr), .map_data(map_data),
      .state(state), .show_map(show_map),
      .player_x(player_x), .player_y(player_y),
      .difficulty(difficulty), .move_count(move_count),
      .won(won), .lost(lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (int'(map_addr) < MAP_H) map_data <= rom[map_addr];
      else                        map_data <= '0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One pulse followed by the REQ and CHECK cycles.
   task automatic do_move(input logic u, input logic d, input logic l, input logic r);
      move_up = u; move_down = d; move_left = l; move_right = r;
      step();
      move_up = 0; move_down = 0; move_left = 0; move_right = 0;
      step();
      step();
   endtask

   task automatic start_game(input logic [1:0] d);
      diff_sel = d;
      start = 1'b1;
      step();
      start = 1'b0;
      diff_sel = 2'd0;
   endtask

   task automatic run_show(output int cnt);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (!show_map) break;
         if (cnt == 1) begin move_up = 1'b1; start = 1'b1; end
         else begin move_up = 1'b0; start = 1'b0; end
         cnt++;
         step();
      end
      move_up = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step(); step();
      reset = 1'b1;
      checks++;
      if (state !== 3'd0 || show_map !== 1'b0 || won !== 1'b0 || lost !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: state=%0d show=%b won=%b lost=%b, want 0 0 0 0", state, show_map, won, lost);
      end
      checks++;
      if (player_x !== 8'd0 || player_y !== 8'd20 || map_addr !== 5'd20) begin
         errors++;
         $display("FAIL reset_pos: x=%0d y=%0d addr=%0d, want 0 20 20", player_x, player_y, map_addr);
      end
      checks++;
      if (move_count !== 3'd0 || difficulty !== 2'd0) begin
         errors++;
         $display("FAIL reset_cnt: cnt=%0d diff=%0d, want 0 0", move_count, difficulty);
      end
   endtask

   task automatic test_show_med();
      int cnt;
      start_game(2'd1);
      checks++;
      if (difficulty !== 2'd1 || state !== 3'd1) begin
         errors++;
         $display("FAIL show_enter: diff=%0d state=%0d, want 1 1", difficulty, state);
      end
      run_show(cnt);
      checks++;
      if (cnt !== S_M || state !== 3'd2) begin
         errors++;
         $display("FAIL show_len: cycles=%0d state=%0d, want %0d 2", cnt, state, S_M);
      end
      checks++;
      if (player_x !== 8'd0 || player_y !== 8'd20 || move_count !== 3'd0) begin
         errors++;
         $display("FAIL show_ignore: x=%0d y=%0d cnt=%0d, want 0 20 0", player_x, player_y, move_count);
      end
   endtask

   task automatic test_bounds();
      move_left = 1'b1;
      step();
      move_left = 1'b0;
      checks++;
      if (state !== 3'd2 || player_x !== 8'd0) begin
         errors++;
         $display("FAIL bound_left: state=%0d x=%0d, want 2 0", state, player_x);
      end
      move_down = 1'b1;
      step();
      move_down = 1'b0;
      checks++;
      if (state !== 3'd2 || player_y !== 8'd20 || move_count !== 3'd0) begin
         errors++;
         $display("FAIL bound_down: state=%0d y=%0d cnt=%0d, want 2 20 0", state, player_y, move_count);
      end
   endtask

   task automatic test_priority();
      move_up = 1'b1; move_right = 1'b1;
      step();
      move_up = 1'b0;
      checks++;
      if (state !== 3'd3 || map_addr !== 5'd19) begin
         errors++;
         $display("FAIL prio_req: state=%0d addr=%0d, want 3 19", state, map_addr);
      end
      step();
      move_right = 1'b0;
      step();
      checks++;
      if (player_x !== 8'd0 || player_y !== 8'd19 || move_count !== 3'd1 || state !== 3'd2) begin
         errors++;
         $display("FAIL prio_commit: x=%0d y=%0d cnt=%0d state=%0d, want 0 19 1 2", player_x, player_y, move_count, state);
      end
      step();
      checks++;
      if (player_x !== 8'd0 || state !== 3'd2) begin
         errors++;
         $display("FAIL req_drop: x=%0d state=%0d, want 0 2", player_x, state);
      end
   endtask

   task automatic test_wall_med();
      do_move(0, 1, 0, 0);
      do_move(0, 0, 0, 1);
      checks++;
      if (player_x !== 8'd1 || player_y !== 8'd20 || move_count !== 3'd3) begin
         errors++;
         $display("FAIL med_setup: x=%0d y=%0d cnt=%0d, want 1 20 3", player_x, player_y, move_count);
      end
      do_move(1, 0, 0, 0);
      checks++;
      if (player_x !== 8'd1 || player_y !== 8'd20 || move_count !== 3'd3 || state !== 3'd2 || map_addr !== 5'd20) begin
         errors++;
         $display("FAIL med_wall: x=%0d y=%0d cnt=%0d state=%0d addr=%0d, want 1 20 3 2 20",
                  player_x, player_y, move_count, state, map_addr);
      end
   endtask

   task automatic test_reset_mid();
      move_right = 1'b1;
      step();
      move_right = 1'b0;
      step();
      checks++;
      if (state !== 3'd4) begin
         errors++;
         $display("FAIL mid_check_reach: state=%0d, want 4", state);
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      checks++;
      if (state !== 3'd0 || player_x !== 8'd0 || player_y !== 8'd20 || move_count !== 3'd0 ||
          map_addr !== 5'd20 || won !== 1'b0 || lost !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: state=%0d x=%0d y=%0d cnt=%0d addr=%0d, want 0 0 20 0 20",
                  state, player_x, player_y, move_count, map_addr);
      end
   endtask

   task automatic test_hard_lost();
      int cnt;
      start_game(2'd3);
      run_show(cnt);
      checks++;
      if (difficulty !== 2'd2 || cnt !== S_H) begin
         errors++;
         $display("FAIL hard_show: diff=%0d cycles=%0d, want 2 %0d", difficulty, cnt, S_H);
      end
      do_move(0, 0, 0, 1);
      do_move(1, 0, 0, 0);
      checks++;
      if (state !== 3'd6 || lost !== 1'b1 || won !== 1'b0 || player_x !== 8'd1 || player_y !== 8'd20 || move_count !== 3'd1) begin
         errors++;
         $display("FAIL hard_lost: state=%0d lost=%b x=%0d y=%0d cnt=%0d, want 6 1 1 20 1",
                  state, lost, player_x, player_y, move_count);
      end
      do_move(0, 0, 1, 0);
      checks++;
      if (state !== 3'd6 || player_x !== 8'd1 || move_count !== 3'd1) begin
         errors++;
         $display("FAIL lost_frozen: state=%0d x=%0d cnt=%0d, want 6 1 1", state, player_x, move_count);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (state !== 3'd0 || lost !== 1'b0 || player_x !== 8'd0 || player_y !== 8'd20) begin
         errors++;
         $display("FAIL lost_exit: state=%0d lost=%b x=%0d y=%0d, want 0 0 0 20", state, lost, player_x, player_y);
      end
   endtask

   task automatic test_easy_win();
      int cnt;
      start_game(2'd0);
      run_show(cnt);
      checks++;
      if (difficulty !== 2'd0 || cnt !== S_E || state !== 3'd2) begin
         errors++;
         $display("FAIL easy_show: diff=%0d cycles=%0d state=%0d, want 0 %0d 2", difficulty, cnt, state, S_E);
      end
      do_move(0, 0, 0, 1);
      do_move(1, 0, 0, 0);
      checks++;
      if (state !== 3'd2 || player_x !== 8'd1 || player_y !== 8'd20 || move_count !== 3'd1) begin
         errors++;
         $display("FAIL easy_wall: state=%0d x=%0d y=%0d cnt=%0d, want 2 1 20 1", state, player_x, player_y, move_count);
      end
      do_move(0, 0, 1, 0);
      for (int i = 0; i < 20; i++) do_move(1, 0, 0, 0);
      checks++;
      if (player_x !== 8'd0 || player_y !== 8'd0 || move_count !== 3'd7) begin
         errors++;
         $display("FAIL climb_sat: x=%0d y=%0d cnt=%0d, want 0 0 7", player_x, player_y, move_count);
      end
      do_move(1, 0, 0, 0);
      checks++;
      if (state !== 3'd2 || player_y !== 8'd0) begin
         errors++;
         $display("FAIL bound_up: state=%0d y=%0d, want 2 0", state, player_y);
      end
      for (int i = 0; i < 28; i++) do_move(0, 0, 0, 1);
      checks++;
      if (player_x !== 8'd28 || state !== 3'd2 || won !== 1'b0) begin
         errors++;
         $display("FAIL pre_goal: x=%0d state=%0d won=%b, want 28 2 0", player_x, state, won);
      end
      do_move(0, 0, 0, 1);
      checks++;
      if (player_x !== 8'd29 || player_y !== 8'd0 || state !== 3'd5 || won !== 1'b1 || move_count !== 3'd7) begin
         errors++;
         $display("FAIL goal: x=%0d y=%0d state=%0d won=%b cnt=%0d, want 29 0 5 1 7",
                  player_x, player_y, state, won, move_count);
      end
      do_move(0, 1, 0, 0);
      checks++;
      if (player_y !== 8'd0 || state !== 3'd5) begin
         errors++;
         $display("FAIL won_frozen: y=%0d state=%0d, want 0 5", player_y, state);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (state !== 3'd0 || won !== 1'b0 || player_x !== 8'd0 || player_y !== 8'd20 || map_addr !== 5'd20) begin
         errors++;
         $display("FAIL won_exit: state=%0d won=%b x=%0d y=%0d addr=%0d, want 0 0 0 20 20",
                  state, won, player_x, player_y, map_addr);
      end
      step();
      checks++;
      if (state !== 3'd0) begin
         errors++;
         $display("FAIL menu_hold: state=%0d, want 0", state);
      end
   endtask

   initial begin
      for (int r = 0; r < MAP_H; r++) rom[r] = '0;
      rom[19] = 30'b10;
      map_data = '0;
      test_reset();
      test_show_med();
      test_bounds();
      test_priority();
      test_wall_med();
      test_reset_mid();
      test_hard_lost();
      test_easy_win();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
